// File: rtl/cpu_pkg.sv
// Shared pipeline constants for the MIPS core stage registers.
// Exception codes, the NOP encoding and the default instruction-memory window.
package cpu_pkg;

    localparam logic [4:0]  EXC_NONE        = 5'd0;
    localparam logic [4:0]  EXC_ADEL        = 5'd4;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam logic [31:0] DEF_IMEM_BASE   = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_LIMIT  = 32'h0000_6FFC;
    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_3000;

    // Per-edge action of a stage register, in priority order flush > hold > load.
    typedef enum logic [1:0] {
        UPD_LOAD  = 2'd0,
        UPD_HOLD  = 2'd1,
        UPD_FLUSH = 2'd2
    } upd_e;

endpackage

// File: rtl/fd_pipe_reg_if.sv
// Fetch-to-decode bundle: fetch-side inputs, hazard/flush controls, decode-side outputs.
// master = fetch/hazard side driving the register, slave = the register itself.
interface fd_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);

    logic [DATA_W-1:0] instr_f;
    logic [ADDR_W-1:0] pc_f;
    logic              valid_f;
    logic              bd_f;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] instr_d;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc8_d;
    logic              valid_d;
    logic              bd_d;
    logic [4:0]        exc_d;

    modport master (
        output instr_f, pc_f, valid_f, bd_f, stall, flush,
        input  instr_d, pc_d, pc8_d, valid_d, bd_d, exc_d
    );

    modport slave (
        input  instr_f, pc_f, valid_f, bd_f, stall, flush,
        output instr_d, pc_d, pc8_d, valid_d, bd_d, exc_d
    );

endinterface

// File: rtl/fd_pipe_reg_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Used for the fetch/decode performance counters.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count register with synchronous clear and saturation at the top value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fd_pipe_reg.sv
// IF/ID pipeline register with valid bit, bubble-inserting flush, delay-slot flag and AdEL capture.
// Optional stall/bubble performance counters when FD_PERF_CNT_EN is defined.
module fd_pipe_reg
    import cpu_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] IMEM_BASE  = DEF_IMEM_BASE,
    parameter logic [ADDR_W-1:0] IMEM_LIMIT = DEF_IMEM_LIMIT,
    parameter logic [ADDR_W-1:0] RESET_PC   = DEF_RESET_PC
) (
    input  logic         clk,
    input  logic         rst_n,
    fd_pipe_reg_if.slave bus
`ifdef FD_PERF_CNT_EN
    ,
    output logic [31:0]  stall_cnt,
    output logic [31:0]  bubble_cnt
`endif
);

    localparam logic [ADDR_W-1:0] PC_STEP8 = ADDR_W'(4'd8);

    // Misaligned or outside the instruction window (both bounds inclusive).
    function automatic logic adel_check(input logic v, input logic [ADDR_W-1:0] pc);
        return v && ((pc[1:0] != 2'b00) || (pc < IMEM_BASE) || (pc > IMEM_LIMIT));
    endfunction

    upd_e              upd_s;
    logic              fault_s;
    logic [DATA_W-1:0] instr_s, instr_r;
    logic [ADDR_W-1:0] pc_s, pc_r;
    logic [ADDR_W-1:0] pc8_s, pc8_r;
    logic              valid_s, valid_r;
    logic              bd_s, bd_r;
    logic [4:0]        exc_s, exc_r;

    // Select the per-edge action.
    always_comb begin
        upd_s = UPD_LOAD;
        if (bus.flush) begin
            upd_s = UPD_FLUSH;
        end else if (bus.stall) begin
            upd_s = UPD_HOLD;
        end else begin
            upd_s = UPD_LOAD;
        end
    end

    // Next contents; a faulting fetch is turned into a NOP carrying AdEL.
    always_comb begin
        fault_s = adel_check(bus.valid_f, bus.pc_f);
        instr_s = instr_r;
        pc_s    = pc_r;
        pc8_s   = pc8_r;
        valid_s = valid_r;
        bd_s    = bd_r;
        exc_s   = exc_r;
        case (upd_s)
            UPD_FLUSH: begin
                instr_s = DATA_W'(NOP_INSTR);
                pc_s    = bus.pc_f;
                pc8_s   = bus.pc_f + PC_STEP8;
                valid_s = 1'b0;
                bd_s    = 1'b0;
                exc_s   = EXC_NONE;
            end
            UPD_HOLD: begin
                instr_s = instr_r;
                pc_s    = pc_r;
            end
            UPD_LOAD: begin
                pc_s    = bus.pc_f;
                pc8_s   = bus.pc_f + PC_STEP8;
                valid_s = bus.valid_f;
                bd_s    = bus.bd_f;
                if (fault_s) begin
                    instr_s = DATA_W'(NOP_INSTR);
                    exc_s   = EXC_ADEL;
                end else if (bus.valid_f) begin
                    instr_s = bus.instr_f;
                    exc_s   = EXC_NONE;
                end else begin
                    instr_s = DATA_W'(NOP_INSTR);
                    exc_s   = EXC_NONE;
                end
            end
            default: begin
                instr_s = instr_r;
            end
        endcase
    end

    // Stage register; reset PC keeps EPC/link values meaningful before the first fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r <= DATA_W'(NOP_INSTR);
            pc_r    <= RESET_PC;
            pc8_r   <= RESET_PC + PC_STEP8;
            valid_r <= 1'b0;
            bd_r    <= 1'b0;
            exc_r   <= EXC_NONE;
        end else begin
            instr_r <= instr_s;
            pc_r    <= pc_s;
            pc8_r   <= pc8_s;
            valid_r <= valid_s;
            bd_r    <= bd_s;
            exc_r   <= exc_s;
        end
    end

    assign bus.instr_d = instr_r;
    assign bus.pc_d    = pc_r;
    assign bus.pc8_d   = pc8_r;
    assign bus.valid_d = valid_r;
    assign bus.bd_d    = bd_r;
    assign bus.exc_d   = exc_r;

`ifdef FD_PERF_CNT_EN
    logic stall_inc_s;
    logic bubble_inc_s;

    assign stall_inc_s  = bus.stall & ~bus.flush;
    assign bubble_inc_s = bus.flush | (~bus.stall & ~bus.valid_f);

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(32)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (bubble_inc_s),
        .count (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Scoreboard bench for fd_pipe_reg: two instances (default window and widened limit)
// share one randomized stimulus stream and are checked against a behavioural model.
module tb_fd_pipe_reg;

    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam logic [31:0] LIM0 = 32'h0000_6FFC;
    localparam logic [31:0] LIM1 = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        valid;
        logic        bd;
        logic [4:0]  exc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;

    always #5 clk = ~clk;

    fd_pipe_reg_if #(.DATA_W(32), .ADDR_W(32)) f0 ();
    fd_pipe_reg_if #(.DATA_W(32), .ADDR_W(32)) f1 ();

    fd_pipe_reg dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (f0)
    );

    fd_pipe_reg #(.IMEM_LIMIT(LIM1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (f1)
    );

    function automatic exp_t reset_state();
        exp_t r;
        r.instr = 32'h0; r.pc = 32'h3000; r.pc8 = 32'h3008;
        r.valid = 1'b0;  r.bd = 1'b0;     r.exc = 5'd0;
        return r;
    endfunction

    // Behavioural next state: plain arithmetic on the stage rules.
    function automatic exp_t step(exp_t cur, logic [31:0] instr, logic [31:0] pc,
                                  logic valid, logic bd, logic stall, logic flush,
                                  logic [31:0] lim);
        exp_t        n;
        logic [63:0] wide;
        bit          fault;
        n    = cur;
        wide = {32'h0, pc} + 64'd8;
        if (flush) begin
            n.instr = 32'h0; n.pc = pc; n.pc8 = wide[31:0];
            n.valid = 1'b0;  n.bd = 1'b0; n.exc = 5'd0;
        end else if (!stall) begin
            fault   = valid && ((pc % 4) != 0 || pc < BASE || pc > lim);
            n.pc    = pc;
            n.pc8   = wide[31:0];
            n.bd    = bd;
            n.valid = valid;
            n.exc   = fault ? 5'd4 : 5'd0;
            n.instr = (valid && !fault) ? instr : 32'h0;
        end
        return n;
    endfunction

    function automatic exp_t sample(input logic [31:0] i, input logic [31:0] p,
                                    input logic [31:0] p8, input logic v,
                                    input logic b, input logic [4:0] e);
        exp_t r;
        r.instr = i; r.pc = p; r.pc8 = p8; r.valid = v; r.bd = b; r.exc = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, want, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t a, input exp_t e);
        chk({tag, ".instr_d"}, a.instr, e.instr);
        chk({tag, ".pc_d"},    a.pc,    e.pc);
        chk({tag, ".pc8_d"},   a.pc8,   e.pc8);
        chk({tag, ".valid_d"}, {31'h0, a.valid}, {31'h0, e.valid});
        chk({tag, ".bd_d"},    {31'h0, a.bd},    {31'h0, e.bd});
        chk({tag, ".exc_d"},   {27'h0, a.exc},   {27'h0, e.exc});
    endtask

    // Reference model: predicts each edge's result and queues it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 = reset_state();
            m1 = reset_state();
            q0.delete();
            q1.delete();
        end else begin
            m0 = step(m0, f0.instr_f, f0.pc_f, f0.valid_f, f0.bd_f, f0.stall, f0.flush, LIM0);
            m1 = step(m1, f1.instr_f, f1.pc_f, f1.valid_f, f1.bd_f, f1.stall, f1.flush, LIM1);
            q0.push_back(m0);
            q1.push_back(m1);
        end
    end

    // Monitor: compare whatever the DUTs present against the queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && q0.size() > 0 && q1.size() > 0) begin
            e = q0.pop_front();
            cmp_all("sb0", sample(f0.instr_d, f0.pc_d, f0.pc8_d, f0.valid_d, f0.bd_d, f0.exc_d), e);
            e = q1.pop_front();
            cmp_all("sb1", sample(f1.instr_d, f1.pc_d, f1.pc8_d, f1.valid_d, f1.bd_d, f1.exc_d), e);
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic valid,
                         input logic bd, input logic stall, input logic flush);
        f0.instr_f = instr; f0.pc_f = pc; f0.valid_f = valid;
        f0.bd_f    = bd;    f0.stall = stall; f0.flush = flush;
        f1.instr_f = instr; f1.pc_f = pc; f1.valid_f = valid;
        f1.bd_f    = bd;    f1.stall = stall; f1.flush = flush;
    endtask

    // Drive at a falling edge, let one rising edge capture, return at the next falling edge.
    task automatic apply(input logic [31:0] instr, input logic [31:0] pc, input logic valid,
                         input logic bd, input logic stall, input logic flush);
        drive(instr, pc, valid, bd, stall, flush);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] edges [6];
        edges[0] = 32'h0000_2FFC; edges[1] = 32'h0000_3000; edges[2] = 32'h0000_6FFC;
        edges[3] = 32'h0000_7000; edges[4] = 32'hFFFF_FFFC; edges[5] = 32'h0000_3001;
        case ($urandom_range(0, 3))
            0:       return 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 32'd4;
            1:       return $urandom;
            2:       return edges[$urandom_range(0, 5)];
            default: return 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 32'd4
                            + 32'($urandom_range(1, 3));
        endcase
    endfunction

    initial begin
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.pc_d",    f0.pc_d,    32'h3000);
        chk("rst.pc8_d",   f0.pc8_d,   32'h3008);
        chk("rst.valid_d", {31'h0, f0.valid_d}, 32'h0);
        chk("rst.instr_d", f0.instr_d, 32'h0);
        rst_n = 1'b1;

        apply(32'h2408_0005, 32'h0000_3004, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("load.pc_d",    f0.pc_d,    32'h3004);
        chk("load.pc8_d",   f0.pc8_d,   32'h300C);
        chk("load.instr_d", f0.instr_d, 32'h2408_0005);
        chk("load.exc_d",   {27'h0, f0.exc_d}, 32'h0);

        for (int i = 0; i < 3; i++) begin
            apply(32'hDEAD_0000 + 32'(i), 32'h3100 + 32'(i) * 32'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        chk("stall.pc_d",    f0.pc_d,    32'h3004);
        chk("stall.instr_d", f0.instr_d, 32'h2408_0005);
        chk("stall.bd_d",    {31'h0, f0.bd_d}, 32'h0);

        apply(32'h1234_5678, 32'h0000_3010, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("flush.instr_d", f0.instr_d, 32'h0);
        chk("flush.valid_d", {31'h0, f0.valid_d}, 32'h0);
        chk("flush.bd_d",    {31'h0, f0.bd_d}, 32'h0);
        chk("flush.pc_d",    f0.pc_d,    32'h3010);

        apply(32'hAAAA_5555, 32'h0000_3002, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("adel_mis.exc_d",   {27'h0, f0.exc_d}, 32'h4);
        chk("adel_mis.instr_d", f0.instr_d, 32'h0);
        apply(32'hAAAA_5555, 32'h0000_7000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("adel_hi.exc_d",  {27'h0, f0.exc_d}, 32'h4);
        chk("wide_7000.exc_d", {27'h0, f1.exc_d}, 32'h0);
        apply(32'h0BAD_F00D, 32'h0000_6FFC, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lim.exc_d",   {27'h0, f0.exc_d}, 32'h0);
        chk("lim.instr_d", f0.instr_d, 32'h0BAD_F00D);
        apply(32'h0000_0021, 32'h0000_3000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("base.exc_d",  {27'h0, f0.exc_d}, 32'h0);
        apply(32'h0000_0022, 32'h0000_2FFC, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("below.exc_d", {27'h0, f0.exc_d}, 32'h4);

        apply(32'h0C00_0010, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("wrap.bd_d",  {31'h0, f1.bd_d}, 32'h1);
        chk("wrap.pc8_d", f1.pc8_d, 32'h0000_0004);
        chk("wrap.exc_d", {27'h0, f1.exc_d}, 32'h0);
        chk("wrap0.exc_d", {27'h0, f0.exc_d}, 32'h4);

        apply(32'h0000_0033, 32'h0000_3020, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.pc_d",    f0.pc_d,    32'h3000);
        chk("async.pc8_d",   f0.pc8_d,   32'h3008);
        chk("async.valid_d", {31'h0, f0.valid_d}, 32'h0);
        chk("async.instr_d", f0.instr_d, 32'h0);
        chk("async.bd_d",    {31'h0, f0.bd_d}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            apply($urandom, rand_pc(), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

        drive(32'h0, 32'h3000, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
